// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one full-subtractor cell is stepped over
// WIDTH cycles, LSB first, behind a start/done handshake.
module serial_sub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, dsr, dsr_nxt;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             d_bit, b_bit, last_bit;

    // Single full-subtractor cell on the current LSBs
    assign d_bit    = sa[0] ^ sb[0] ^ br;
    assign b_bit    = (~sa[0] & (sb[0] | br)) | (sb[0] & br);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign dsr_nxt  = {d_bit, {(WIDTH-1){1'b0}}} | (dsr >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (abort)         state_nxt = IDLE;
                else if (last_bit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Partial difference accumulates in dsr; diff/bout change only on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            dsr  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= bin;
                        cnt <= '0;
                        dsr <= '0;
                    end
                end
                RUN: begin
                    if (!abort) begin
                        sa  <= sa >> 1;
                        sb  <= sb >> 1;
                        br  <= b_bit;
                        cnt <= cnt + CNT_W'(1);
                        dsr <= dsr_nxt;
                        if (last_bit) begin
                            diff <= dsr_nxt;
                            bout <= b_bit;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
